// File: rtl/alu_arbiter_ctrl.sv
// Round-robin front end that shares one 64-bit ALU between two requesters.
// Optional sticky overflow flag enabled by defining ALU_OVF_STICKY_EN.
module alu_arbiter_ctrl #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_opcode,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_opcode,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_ovf,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_ainvert,
    output logic             alu_binvert,
    output logic             alu_cin,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic [CNT_W-1:0] op_count,
    input  logic             clr_sticky,
    output logic             ovf_sticky
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic             last_grant;
    logic             cur_id;
    logic             cur_err;
    logic             cur_arith;
    logic             grant_any;
    logic             grant_id;
    logic             idle_grant;
    logic [2:0]       sel_opcode;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             dec_ainv;
    logic             dec_binv;
    logic [1:0]       dec_op;
    logic             dec_cin;
    logic             dec_err;
    logic             dec_arith;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_id  = ~last_grant;
        end else if (req0_valid) begin
            grant_any = 1'b1;
        end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign idle_grant = rst_n && (state == IDLE) && grant_any;
    assign req0_ready = idle_grant && !grant_id;
    assign req1_ready = idle_grant && grant_id;

    assign sel_opcode = grant_id ? req1_opcode : req0_opcode;
    assign sel_a      = grant_id ? req1_a : req0_a;
    assign sel_b      = grant_id ? req1_b : req0_b;

    always_comb begin
        dec_ainv  = 1'b0;
        dec_binv  = 1'b0;
        dec_op    = 2'b00;
        dec_cin   = 1'b0;
        dec_err   = 1'b0;
        dec_arith = 1'b0;
        case (sel_opcode)
            3'b000: dec_op = 2'b00;
            3'b001: dec_op = 2'b01;
            3'b010: begin dec_op = 2'b10; dec_arith = 1'b1; end
            3'b011: begin dec_binv = 1'b1; dec_op = 2'b10; dec_cin = 1'b1; dec_arith = 1'b1; end
            3'b100: begin dec_ainv = 1'b1; dec_binv = 1'b1; dec_op = 2'b01; end
            3'b101: begin dec_ainv = 1'b1; dec_binv = 1'b1; dec_op = 2'b00; end
            3'b110: begin dec_binv = 1'b1; dec_op = 2'b11; dec_cin = 1'b1; dec_arith = 1'b1; end
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cur_id      <= 1'b0;
            cur_err     <= 1'b0;
            cur_arith   <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ainvert <= 1'b0;
            alu_binvert <= 1'b0;
            alu_cin     <= 1'b0;
            alu_op      <= 2'b00;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_ovf    <= 1'b0;
            resp_err    <= 1'b0;
            op_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        alu_a       <= sel_a;
                        alu_b       <= sel_b;
                        alu_ainvert <= dec_ainv;
                        alu_binvert <= dec_binv;
                        alu_op      <= dec_op;
                        alu_cin     <= dec_cin;
                        cur_id      <= grant_id;
                        cur_err     <= dec_err;
                        cur_arith   <= dec_arith;
                        last_grant  <= grant_id;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    resp_id    <= cur_id;
                    resp_err   <= cur_err;
                    resp_valid <= 1'b1;
                    if (cur_err) begin
                        resp_result <= '0;
                        resp_zero   <= 1'b0;
                        resp_ovf    <= 1'b0;
                    end else begin
                        resp_result <= alu_result;
                        resp_zero   <= alu_zero;
                        resp_ovf    <= cur_arith && alu_overflow;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        op_count   <= op_count + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_OVF_STICKY_EN
    // A completing overflow response takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (resp_valid && resp_ready && resp_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign ovf_sticky = 1'b0;
`endif

endmodule

// File: doc/alu_arbiter_ctrl.md
Name: alu_arbiter_ctrl

Overview:
- Shares one combinational 64-bit ALU (AND/OR/add, with Ainvert, Binvert, op, cin controls) between two requesters.
- Round-robin arbitration; decodes a 3-bit opcode into ALU control lines; latches operands; captures result, zero and overflow; returns them over a valid/ready response channel tagged with requester id.
- Sits between issuing units (sequencer, test driver) and the ALU instance.

Parameters:
- WIDTH, 64, operand and result width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_opcode  input  3  requester 0 opcode.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b  same as req0, for requester 1.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer takes response.
- resp_id  output  1  requester that issued the command.
- resp_result  output  WIDTH  captured ALU result.
- resp_zero  output  1  captured zero flag.
- resp_ovf  output  1  captured overflow; 0 for non-arithmetic opcodes.
- resp_err  output  1  reserved opcode.
- alu_a, alu_b  output  WIDTH  ALU operands (registered).
- alu_ainvert, alu_binvert, alu_cin  output  1  ALU controls (registered).
- alu_op  output  2  ALU op select (registered).
- alu_result  input  WIDTH  ALU result.
- alu_zero, alu_overflow  input  1  ALU flags.
- op_count  output  CNT_W  completed responses; wraps modulo 2^CNT_W.
- clr_sticky  input  1  clears ovf_sticky.
- ovf_sticky  output  1  sticky overflow (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): FSM=IDLE. All outputs 0: resp_*, alu_*, op_count, ovf_sticky, reqX_ready. last_grant=1, so req0 wins the first contention.
- Opcode decode (ainvert, binvert, op, cin):
  - 000 AND = 0,0,00,0
  - 001 OR = 0,0,01,0
  - 010 ADD = 0,0,10,0
  - 011 SUB = 0,1,10,1
  - 100 NAND = 1,1,01,0
  - 101 NOR = 1,1,00,0
  - 110 SLT = 0,1,11,1
  - 111 reserved: controls 0, err.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqX_ready is combinational: high only for the granted requester, only in IDLE.
  - Grant rule: if only one valid, grant it. If both valid, grant the one != last_grant.
  - On grant: register alu_* from the granted command, store id and err, update last_grant, go to EXEC.
  - Never both readies high in the same cycle.
- EXEC (one cycle; ALU settles):
  - At the clock edge, capture alu_result and alu_zero into resp_result and resp_zero.
  - resp_ovf = alu_overflow only for ADD, SUB and SLT; else 0.
  - If err: resp_result=0, resp_zero=0, resp_ovf=0.
  - Go to RESP.
- RESP:
  - resp_valid=1. resp_* stay stable while resp_ready=0.
  - On resp_valid & resp_ready: resp_valid=0, op_count+1, go to IDLE.
  - No new grant in the same cycle.
- Latency:
  - Accept in cycle N -> resp_valid in cycle N+2.
  - Minimum issue interval 3 cycles with resp_ready held high.
- alu_* outputs hold their last values outside EXEC.
- Back-pressure: while not IDLE, both readies are low, so requesters must hold their commands.
- op_count wraps from 2^CNT_W-1 to 0.
- rst_n low mid-operation: immediate return to reset state; in-flight command is dropped with no response.

Optional Feature:
- Macro: ALU_OVF_STICKY_EN.
- Defined:
  - ovf_sticky sets on a completed response with resp_ovf=1.
  - clr_sticky clears it.
  - If set and clear coincide, set wins.
- Undefined: ovf_sticky tied 0; clr_sticky ignored; ports remain present.

Test Plan:
- AND via req0: a=0, b=all ones, opcode 000 -> ALU driven 0,0,00,0; resp_result=0, resp_zero=1, resp_id=0, resp_valid at cycle N+2.
- ADD overflow via req1: a=b=0x7FFF_FFFF_FFFF_FFFF -> resp_result=0xFFFF_FFFF_FFFF_FFFE, resp_ovf=1. With ALU_OVF_STICKY_EN, ovf_sticky=1 until clr_sticky pulses.
- Both requesters valid continuously:
  - Grants alternate 0,1,0,1 after reset.
  - Never both readies high.
  - op_count=4 after four handshakes.
- resp_ready held low 5 cycles during a SUB (a=5, b=5):
  - resp_result=0 and resp_zero=1 stay stable.
  - Requester ready stays low.
  - Completes one cycle after resp_ready rises.
- Opcode 111 -> resp_err=1, resp_result=0, resp_ovf=0; op_count increments.
- rst_n pulsed low while in EXEC -> all outputs 0 immediately; no response emitted; next grant goes to req0.
